// File: rtl/spi_cmd_router_if.sv
// Byte-stream and memory-port bundle for spi_cmd_router.
// master = router side, slave = SPI slave / memory side.
interface spi_cmd_router_if #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned WIDTH_ADDR = 13,
    parameter int unsigned WIDTH_WORD = 128
);
    logic                       cs_active;
    logic                       rx_valid;
    logic [7:0]                 rx_byte;
    logic [7:0]                 tx_byte;
    logic                       tx_valid;
    logic                       tx_ready;
    logic [N_CH-1:0]            mem_wren;
    logic [N_CH-1:0]            mem_rden;
    logic [WIDTH_ADDR-1:0]      mem_addr;
    logic [WIDTH_WORD-1:0]      mem_data;
    logic [N_CH*WIDTH_WORD-1:0] mem_q;
    logic                       sel_ext;
    logic                       proc_enable;
    logic                       proc_reset;
    logic                       err;

    modport master (
        input  cs_active, rx_valid, rx_byte, tx_ready, mem_q,
        output tx_byte, tx_valid, mem_wren, mem_rden, mem_addr, mem_data,
               sel_ext, proc_enable, proc_reset, err
    );

    modport slave (
        output cs_active, rx_valid, rx_byte, tx_ready, mem_q,
        input  tx_byte, tx_valid, mem_wren, mem_rden, mem_addr, mem_data,
               sel_ext, proc_enable, proc_reset, err
    );
endinterface

// File: rtl/spi_cmd_router.sv
// Routes framed SPI byte streams to N one-hot memory channels plus a control register.
// Word readback is compiled in only when SPI_CMD_ROUTER_READBACK_EN is defined.
module spi_cmd_router #(
    parameter int unsigned       N_CH          = 4,
    parameter int unsigned       WIDTH_ADDR    = 13,
    parameter int unsigned       WIDTH_WORD    = 128,
    parameter logic [8*N_CH-1:0] CH_WORD_BYTES = {8'd10, 8'd16, 8'd1, 8'd1},
    parameter int unsigned       RD_LATENCY    = 2
) (
    input logic              clk,
    input logic              reset_n,
    spi_cmd_router_if.master bus
);
    localparam int unsigned ADDR_BYTES = (WIDTH_ADDR + 7) / 8;
    localparam int unsigned WORD_BYTES = WIDTH_WORD / 8;

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] HDR   = 4'd1;
    localparam logic [3:0] ADDR  = 4'd2;
    localparam logic [3:0] WDATA = 4'd3;
    localparam logic [3:0] CTRL  = 4'd4;
    localparam logic [3:0] DROP  = 4'd5;
`ifdef SPI_CMD_ROUTER_READBACK_EN
    localparam logic [3:0] RD_ISSUE = 4'd6;
    localparam logic [3:0] RD_WAIT  = 4'd7;
    localparam logic [3:0] RD_SEND  = 4'd8;
`endif

    logic [3:0]            state_q, state_d;
    logic                  cs_q;
    logic [7:0]            cnt_q, cnt_d;
    logic [5:0]            ch_q, ch_d;
    logic [WIDTH_ADDR-1:0] addr_q, addr_d;
    logic [WIDTH_WORD-1:0] word_q, word_d, word_ins;
    logic [WIDTH_WORD-1:0] data_q, data_d;
    logic [N_CH-1:0]       wren_q, wren_d;
    logic                  err_q, err_d, sel_q, sel_d, en_q, en_d, prst_q, prst_d;

    logic                  rx_ok, hdr_bad, last_byte;
    logic [7:0]            ch_bytes;
    logic [N_CH-1:0]       ch_onehot;
    logic [WIDTH_ADDR+7:0] addr_shift;

`ifdef SPI_CMD_ROUTER_READBACK_EN
    logic                  rd_q, rd_d, txv_q, txv_d;
    logic [7:0]            txb_q, txb_d;
    logic [WIDTH_WORD-1:0] rdata_q, rdata_d, q_slice;
`endif

    // A byte arriving as cs drops belongs to no frame.
    assign rx_ok      = bus.rx_valid & bus.cs_active;
    assign ch_onehot  = N_CH'(1) << ch_q;
    assign addr_shift = {addr_q, bus.rx_byte};
    assign last_byte  = (cnt_q == ch_bytes - 8'd1);
`ifdef SPI_CMD_ROUTER_READBACK_EN
    assign hdr_bad = ({2'b00, bus.rx_byte[5:0]} >= 8'(N_CH));
`else
    assign hdr_bad = ({2'b00, bus.rx_byte[5:0]} >= 8'(N_CH)) | bus.rx_byte[7];
`endif

    always_comb begin
        ch_bytes = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            if (ch_q == 6'(c)) ch_bytes = CH_WORD_BYTES[c*8 +: 8];
        end
    end

    always_comb begin
        word_ins = word_q;
        for (int b = 0; b < int'(WORD_BYTES); b++) begin
            if (cnt_q == 8'(b)) word_ins[b*8 +: 8] = bus.rx_byte;
        end
    end

`ifdef SPI_CMD_ROUTER_READBACK_EN
    always_comb begin
        q_slice = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            if (ch_q == 6'(c)) q_slice = bus.mem_q[c*WIDTH_WORD +: WIDTH_WORD];
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        addr_d  = addr_q;
        word_d  = word_q;
        data_d  = data_q;
        wren_d  = '0;
        err_d   = err_q;
        sel_d   = sel_q;
        en_d    = en_q;
        prst_d  = 1'b0;
`ifdef SPI_CMD_ROUTER_READBACK_EN
        rd_d    = rd_q;
        txv_d   = txv_q;
        txb_d   = txb_q;
        rdata_d = rdata_q;
`endif
        // Address advances the cycle after the strobe so mem_addr holds during it.
        if (wren_q != '0) addr_d = addr_q + WIDTH_ADDR'(1);

        case (state_q)
            IDLE: begin
                if (bus.cs_active && !cs_q) begin
                    state_d = HDR;
                    cnt_d   = '0;
                    word_d  = '0;
                end
            end
            HDR: begin
                if (rx_ok) begin
                    ch_d  = bus.rx_byte[5:0];
                    cnt_d = '0;
                    if (bus.rx_byte[6]) begin
                        state_d = CTRL;
                    end else if (hdr_bad) begin
                        state_d = DROP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ADDR;
                        sel_d   = 1'b1;
`ifdef SPI_CMD_ROUTER_READBACK_EN
                        rd_d    = bus.rx_byte[7];
`endif
                    end
                end
            end
            ADDR: begin
                if (rx_ok) begin
                    addr_d = addr_shift[WIDTH_ADDR-1:0];
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == 8'(ADDR_BYTES - 1)) begin
                        cnt_d   = '0;
                        word_d  = '0;
                        state_d = WDATA;
`ifdef SPI_CMD_ROUTER_READBACK_EN
                        if (rd_q) state_d = RD_ISSUE;
`endif
                    end
                end
            end
            WDATA: begin
                if (rx_ok) begin
                    if (last_byte) begin
                        wren_d = ch_onehot;
                        data_d = word_ins;
                        word_d = '0;
                        cnt_d  = '0;
                    end else begin
                        word_d = word_ins;
                        cnt_d  = cnt_q + 8'd1;
                    end
                end
            end
            CTRL: begin
                if (rx_ok) begin
                    en_d   = bus.rx_byte[0];
                    prst_d = bus.rx_byte[1];
                    if (bus.rx_byte[2]) err_d = 1'b0;
                    state_d = DROP;
                end
            end
            DROP: ;
`ifdef SPI_CMD_ROUTER_READBACK_EN
            RD_ISSUE: begin
                cnt_d   = 8'd1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (cnt_q == 8'(RD_LATENCY)) begin
                    txb_d   = q_slice[7:0];
                    rdata_d = q_slice >> 8;
                    txv_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = RD_SEND;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RD_SEND: begin
                if (txv_q && bus.tx_ready) begin
                    if (last_byte) begin
                        txv_d   = 1'b0;
                        cnt_d   = '0;
                        addr_d  = addr_q + WIDTH_ADDR'(1);
                        state_d = RD_ISSUE;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        txb_d   = rdata_q[7:0];
                        rdata_d = rdata_q >> 8;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && !bus.cs_active) begin
            state_d = IDLE;
            sel_d   = 1'b0;
            word_d  = '0;
            cnt_d   = '0;
`ifdef SPI_CMD_ROUTER_READBACK_EN
            txv_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cs_q    <= 1'b1;  // a frame already in progress at reset is not entered
            cnt_q   <= '0;
            ch_q    <= '0;
            addr_q  <= '0;
            word_q  <= '0;
            data_q  <= '0;
            wren_q  <= '0;
            err_q   <= 1'b0;
            sel_q   <= 1'b0;
            en_q    <= 1'b0;
            prst_q  <= 1'b0;
`ifdef SPI_CMD_ROUTER_READBACK_EN
            rd_q    <= 1'b0;
            txv_q   <= 1'b0;
            txb_q   <= '0;
            rdata_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cs_q    <= bus.cs_active;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            prst_q  <= prst_d;
`ifdef SPI_CMD_ROUTER_READBACK_EN
            rd_q    <= rd_d;
            txv_q   <= txv_d;
            txb_q   <= txb_d;
            rdata_q <= rdata_d;
`endif
        end
    end

    assign bus.mem_wren    = wren_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_data    = data_q;
    assign bus.sel_ext     = sel_q;
    assign bus.proc_enable = en_q;
    assign bus.proc_reset  = prst_q;
    assign bus.err         = err_q;
`ifdef SPI_CMD_ROUTER_READBACK_EN
    assign bus.mem_rden = (state_q == RD_ISSUE) ? ch_onehot : '0;
    assign bus.tx_byte  = txb_q;
    assign bus.tx_valid = txv_q;
`else
    logic unused_rd;
    assign unused_rd    = ^{bus.tx_ready, bus.mem_q};
    assign bus.mem_rden = '0;
    assign bus.tx_byte  = '0;
    assign bus.tx_valid = 1'b0;
`endif
endmodule

// File: tb/tb_spi_cmd_router.sv
// Self-checking bench for spi_cmd_router: table rows, hand sequences, random frames
// checked against a byte-stream model of the framing rules.
module tb_spi_cmd_router;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    spi_cmd_router_if #(.N_CH(4), .WIDTH_ADDR(13), .WIDTH_WORD(128)) bus ();

    // ch0=1, ch1=16, ch2=1, ch3=10 bytes per word
    spi_cmd_router #(
        .N_CH(4), .WIDTH_ADDR(13), .WIDTH_WORD(128),
        .CH_WORD_BYTES(32'h0A01_1001), .RD_LATENCY(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct {
        logic [3:0]   en;
        logic [12:0]  addr;
        logic [127:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]  hdr;
        logic [15:0] addr;
        int          n;
        logic [7:0]  base;
        logic [7:0]  stride;
        int          exp_wr;
        logic        exp_err;
        logic        exp_sel;
        logic [12:0] exp_first;
    } vec_t;

    int   n_checks = 0;
    int   n_fail = 0;
    int   prst_cnt = 0;
    int   txv_cnt = 0;
    int   nb_tab[4] = '{1, 16, 1, 10};
    wr_t  got[$];
    wr_t  exp_q[$];
    vec_t vecs[$];
    logic [7:0] d[$];
    logic m_err = 1'b0;
    logic m_en = 1'b0;
    int   m_prst = 0;
    logic sel_mid;

    always @(negedge clk) begin
        if (bus.mem_wren != 4'b0) got.push_back('{bus.mem_wren, bus.mem_addr, bus.mem_data});
        if (bus.proc_reset) prst_cnt++;
        if (bus.tx_valid) txv_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish within the time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        step(1);
        bus.rx_valid = 1'b0;
        step(gap);
    endtask

    function automatic int rgap(input int maxgap);
        return (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
    endfunction

    // Expected writes of one data frame: LSB-first words, address wraps mod 2^13.
    task automatic model_write(input logic [7:0] hdr, input logic [15:0] a16);
        int ch, nb, k;
        logic [12:0] a;
        logic [127:0] w;
        ch = int'(hdr[5:0]);
        if (ch >= 4) begin
            m_err = 1'b1;
            return;
        end
        if (hdr[7]) begin
`ifndef SPI_CMD_ROUTER_READBACK_EN
            m_err = 1'b1;
`endif
            return;
        end
        nb = nb_tab[ch];
        a  = a16[12:0];
        w  = '0;
        k  = 0;
        foreach (d[i]) begin
            w = w | (128'(d[i]) << (8 * k));
            k++;
            if (k == nb) begin
                exp_q.push_back('{4'(1 << ch), a, w});
                a = a + 13'd1;
                w = '0;
                k = 0;
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] hdr, input logic [15:0] a16, input int maxgap,
                             output logic sel_seen);
        bus.cs_active = 1'b1;
        step(2);
        send_byte(hdr, rgap(maxgap));
        send_byte(a16[15:8], rgap(maxgap));
        send_byte(a16[7:0], 0);
        sel_seen = bus.sel_ext;
        foreach (d[i]) send_byte(d[i], rgap(maxgap));
        step(1);
        bus.cs_active = 1'b0;
        step(3);
    endtask

    task automatic ctrl_frame(input logic [7:0] hdr, input logic [7:0] b);
        bus.cs_active = 1'b1;
        step(2);
        send_byte(hdr, 1);
        send_byte(b, 0);
        send_byte(8'($urandom), 0);
        step(1);
        bus.cs_active = 1'b0;
        step(3);
        m_en = b[0];
        if (b[1]) m_prst++;
        if (b[2]) m_err = 1'b0;
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_wr_count"}, 128'(got.size()), 128'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            check({tag, "_wren"}, 128'(got[i].en), 128'(exp_q[i].en));
            check({tag, "_addr"}, 128'(got[i].addr), 128'(exp_q[i].addr));
            check({tag, "_data"}, got[i].data, exp_q[i].data);
        end
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        bus.cs_active = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_byte   = 8'h00;
        bus.tx_ready  = 1'b0;
        bus.mem_q     = '0;

        // Reset values
        step(3);
        check("rst_wren", 128'(bus.mem_wren), 128'h0);
        check("rst_rden", 128'(bus.mem_rden), 128'h0);
        check("rst_txv", 128'(bus.tx_valid), 128'h0);
        check("rst_txb", 128'(bus.tx_byte), 128'h0);
        check("rst_sel", 128'(bus.sel_ext), 128'h0);
        check("rst_en", 128'(bus.proc_enable), 128'h0);
        check("rst_prst", 128'(bus.proc_reset), 128'h0);
        check("rst_err", 128'(bus.err), 128'h0);
        reset_n = 1'b1;
        step(2);

        // Strobe lands the cycle after the completing byte
        bus.cs_active = 1'b1;
        step(2);
        send_byte(8'h00, 1);
        send_byte(8'h00, 1);
        send_byte(8'h42, 1);
        send_byte(8'h99, 0);
        check("wr_timing_wren", 128'(bus.mem_wren), 128'h1);
        check("wr_timing_addr", 128'(bus.mem_addr), 128'h42);
        check("wr_timing_data", bus.mem_data, 128'h99);
        step(1);
        check("wr_timing_pulse", 128'(bus.mem_wren), 128'h0);
        bus.cs_active = 1'b0;
        step(3);
        got.delete();

        vecs.push_back('{8'h02, 16'h0100, 2, 8'hAA, 8'h11, 2, 1'b0, 1'b1, 13'h0100});
        vecs.push_back('{8'h01, 16'h1FFF, 21, 8'h00, 8'h01, 1, 1'b0, 1'b1, 13'h1FFF});
        vecs.push_back('{8'h00, 16'h1FFE, 3, 8'h10, 8'h01, 3, 1'b0, 1'b1, 13'h1FFE});
        vecs.push_back('{8'h03, 16'hE005, 25, 8'h30, 8'h03, 2, 1'b0, 1'b1, 13'h0005});
        vecs.push_back('{8'h05, 16'h0000, 3, 8'h00, 8'h01, 0, 1'b1, 1'b0, 13'h0});
        vecs.push_back('{8'h3F, 16'h0000, 2, 8'h00, 8'h01, 0, 1'b1, 1'b0, 13'h0});
        vecs.push_back('{8'h01, 16'h0000, 15, 8'h50, 8'h01, 0, 1'b0, 1'b1, 13'h0});
`ifdef SPI_CMD_ROUTER_READBACK_EN
        vecs.push_back('{8'h82, 16'h0010, 2, 8'h00, 8'h01, 0, 1'b0, 1'b1, 13'h0});
`else
        vecs.push_back('{8'h82, 16'h0010, 2, 8'h00, 8'h01, 0, 1'b1, 1'b0, 13'h0});
`endif

        foreach (vecs[r]) begin
            ctrl_frame(8'h40, 8'h04);
            check("row_err_clear", 128'(bus.err), 128'h0);
            got.delete();
            d.delete();
            for (int k = 0; k < vecs[r].n; k++) d.push_back(8'(vecs[r].base + k * vecs[r].stride));
            model_write(vecs[r].hdr, vecs[r].addr);
            run_frame(vecs[r].hdr, vecs[r].addr, 1, sel_mid);
            check("row_sel_mid", 128'(sel_mid), 128'(vecs[r].exp_sel));
            check("row_wr_count", 128'(got.size()), 128'(vecs[r].exp_wr));
            if (vecs[r].exp_wr > 0 && got.size() > 0)
                check("row_first_addr", 128'(got[0].addr), 128'(vecs[r].exp_first));
            compare_writes("row");
            check("row_err", 128'(bus.err), 128'(vecs[r].exp_err));
            check("row_sel_after", 128'(bus.sel_ext), 128'h0);
        end

        // Control frame: enable plus one-cycle processor reset
        prst_cnt = 0;
        bus.cs_active = 1'b1;
        step(2);
        send_byte(8'h40, 1);
        send_byte(8'h03, 0);
        check("ctrl_prst_high", 128'(bus.proc_reset), 128'h1);
        check("ctrl_en", 128'(bus.proc_enable), 128'h1);
        step(1);
        check("ctrl_prst_low", 128'(bus.proc_reset), 128'h0);
        bus.cs_active = 1'b0;
        step(3);
        check("ctrl_prst_cycles", 128'(prst_cnt), 128'h1);

        // Invalid channel sets err, control byte 0x05 clears it and enables
        d.delete();
        d.push_back(8'h11);
        run_frame(8'h05, 16'h0000, 0, sel_mid);
        check("inv_err", 128'(bus.err), 128'h1);
        ctrl_frame(8'h40, 8'h05);
        check("inv_ctrl_en", 128'(bus.proc_enable), 128'h1);
        check("inv_ctrl_err", 128'(bus.err), 128'h0);

        // cs falls together with the completing byte: no write
        got.delete();
        bus.cs_active = 1'b1;
        step(2);
        send_byte(8'h00, 1);
        send_byte(8'h00, 1);
        send_byte(8'h20, 1);
        bus.rx_valid  = 1'b1;
        bus.rx_byte   = 8'h77;
        bus.cs_active = 1'b0;
        step(1);
        bus.rx_valid = 1'b0;
        step(3);
        check("csfall_no_write", 128'(got.size()), 128'h0);

        // Reset mid-frame abandons the frame even with cs still high
        bus.cs_active = 1'b1;
        step(2);
        send_byte(8'h00, 1);
        send_byte(8'h00, 1);
        check("rstmid_sel_before", 128'(bus.sel_ext), 128'h1);
        reset_n = 1'b0;
        step(1);
        check("rstmid_sel", 128'(bus.sel_ext), 128'h0);
        check("rstmid_en", 128'(bus.proc_enable), 128'h0);
        reset_n = 1'b1;
        send_byte(8'h30, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 1);
        check("rstmid_no_write", 128'(got.size()), 128'h0);
        bus.cs_active = 1'b0;
        step(3);
        m_err = 1'b0;
        m_en  = 1'b0;

`ifdef SPI_CMD_ROUTER_READBACK_EN
        // Readback: rden, data RD_LATENCY+1 cycles later, next word after handshake
        bus.mem_q[2*128 +: 8] = 8'h5A;
        bus.cs_active = 1'b1;
        step(2);
        send_byte(8'h82, 1);
        send_byte(8'h00, 1);
        send_byte(8'h10, 0);
        check("rd_rden", 128'(bus.mem_rden), 128'h4);
        check("rd_addr", 128'(bus.mem_addr), 128'h10);
        step(1);
        check("rd_rden_pulse", 128'(bus.mem_rden), 128'h0);
        step(1);
        check("rd_txv_early", 128'(bus.tx_valid), 128'h0);
        step(1);
        check("rd_txv", 128'(bus.tx_valid), 128'h1);
        check("rd_txb", 128'(bus.tx_byte), 128'h5A);
        step(2);
        check("rd_txv_held", 128'(bus.tx_valid), 128'h1);
        bus.tx_ready = 1'b1;
        step(1);
        bus.tx_ready = 1'b0;
        check("rd_next_rden", 128'(bus.mem_rden), 128'h4);
        check("rd_next_addr", 128'(bus.mem_addr), 128'h11);
        bus.cs_active = 1'b0;
        step(2);
        check("rd_txv_dropped", 128'(bus.tx_valid), 128'h0);
        step(2);
`else
        check("norb_txv_never", 128'(txv_cnt), 128'h0);
`endif

        // Random frames against the model
        for (int it = 0; it < 40; it++) begin
            got.delete();
            exp_q.delete();
            if ($urandom_range(4, 0) == 0) begin
                logic [7:0] h, b;
                h = 8'h40 | 8'($urandom_range(63, 0)) | ($urandom_range(1, 0) != 0 ? 8'h80 : 8'h00);
                b = 8'($urandom);
                prst_cnt = 0;
                m_prst = 0;
                ctrl_frame(h, b);
                check("rnd_ctrl_en", 128'(bus.proc_enable), 128'(m_en));
                check("rnd_ctrl_prst", 128'(prst_cnt), 128'(m_prst));
            end else begin
                logic [7:0] h;
                logic [15:0] a;
                h = 8'($urandom_range(5, 0));
                a = 16'($urandom);
                d.delete();
                for (int k = 0; k < int'($urandom_range(35, 0)); k++) d.push_back(8'($urandom));
                model_write(h, a);
                run_frame(h, a, 2, sel_mid);
                compare_writes("rnd");
            end
            check("rnd_err", 128'(bus.err), 128'(m_err));
            check("rnd_sel_after", 128'(bus.sel_ext), 128'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
